// File: rtl/adrv9001_tx_serdes_framer_pkg.sv
`default_nettype none
// ============================================================================
// Module  : adrv9001_tx_serdes_framer_pkg
// Brief   : Shared constants, types and lane helpers for the TX serdes framer.
// Revision: 1.0 - initial release
// ============================================================================
package adrv9001_tx_serdes_framer_pkg;

  localparam int PHASE_W = 4;
  localparam int WORD_W  = 16;

  localparam logic [WORD_W-1:0] STRB_PAT_8ON = 16'hFF00;
  localparam logic [WORD_W-1:0] STRB_PAT_1ON = 16'h8000;

  typedef enum logic {
    STRB_MODE_8ON = 1'b0,
    STRB_MODE_1ON = 1'b1
  } strb_mode_e;

  // One buffered I/Q sample
  typedef struct packed {
    logic [WORD_W-1:0] i;
    logic [WORD_W-1:0] q;
  } iq_sample_t;

  function automatic logic [WORD_W-1:0] strb_pattern(input strb_mode_e mode);
    return (mode == STRB_MODE_1ON) ? STRB_PAT_1ON : STRB_PAT_8ON;
  endfunction

  // Phase N>0 takes the low N bits of the older word followed by the top
  // 16-N bits of the newer word; N=0 ships the older word untouched.
  function automatic logic [WORD_W-1:0] lane_shift(input logic [WORD_W-1:0]  prev,
                                                   input logic [WORD_W-1:0]  cur,
                                                   input logic [PHASE_W-1:0] n);
    logic [2*WORD_W-1:0] w_cat;
    w_cat = {prev, cur} >> n;
    return (n == '0) ? prev : w_cat[WORD_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/adrv9001_tx_serdes_framer_if.sv
`default_nettype none
// ============================================================================
// Module  : adrv9001_tx_serdes_framer_if
// Brief   : Sample handshake in, three-lane serdes words out.
// Revision: 1.0 - initial release
// ============================================================================
interface adrv9001_tx_serdes_framer_if;

  logic [15:0] i_in;
  logic [15:0] q_in;
  logic        valid_in;
  logic        ready_out;
  logic [15:0] i_out;
  logic [15:0] q_out;
  logic [15:0] strb_out;
  logic        valid_out;

  // Sample source / lane consumer side
  modport master (
    output i_in, q_in, valid_in,
    input  ready_out, i_out, q_out, strb_out, valid_out
  );

  // Framer side
  modport slave (
    input  i_in, q_in, valid_in,
    output ready_out, i_out, q_out, strb_out, valid_out
  );

endinterface
`default_nettype wire

// File: rtl/adrv9001_tx_serdes_framer_fifo.sv
`default_nettype none
// ============================================================================
// Module  : adrv9001_tx_serdes_framer_fifo
// Brief   : Synchronous I/Q sample FIFO with flush, full and empty flags.
// Revision: 1.0 - initial release
// ============================================================================
module adrv9001_tx_serdes_framer_fifo
  import adrv9001_tx_serdes_framer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  wire        clk,
  input  wire        rstn,
  input  wire        flush,
  input  wire        push,
  input  iq_sample_t wdata,
  input  wire        pop,
  output iq_sample_t rdata,
  output logic       full,
  output logic       empty
);

  localparam int            AW      = $clog2(DEPTH);
  localparam logic [AW:0]   C_DEPTH = (AW+1)'(DEPTH);

  iq_sample_t    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign full   = (r_count == C_DEPTH);
  assign empty  = (r_count == '0);
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;
  assign rdata  = r_mem[r_rptr];

  // Sample storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  // Pointers and occupancy; flush discards everything buffered
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/adrv9001_tx_serdes_framer.sv
`default_nettype none
// ============================================================================
// Module  : adrv9001_tx_serdes_framer
// Brief   : Buffers TX I/Q samples and emits phase-shifted 16-bit words for
//           the I, Q and strobe OSERDES lanes (MSB first).
// Revision: 1.0 - initial release
// ============================================================================
module adrv9001_tx_serdes_framer
  import adrv9001_tx_serdes_framer_pkg::*;
#(
  parameter int          FIFO_DEPTH = 4,
  parameter logic [15:0] IDLE_I     = 16'h0000,
  parameter logic [15:0] IDLE_Q     = 16'h0000
) (
  input  wire                      clk,
  input  wire                      rstn,
  input  wire                      enable,
  input  wire                      strb_mode,
  input  wire [PHASE_W-1:0]        phase,
  adrv9001_tx_serdes_framer_if.slave bus,
  output logic                     underflow,
  output logic [15:0]              uflow_cnt
);

  logic               r_en_d1;
  strb_mode_e         r_mode;
  logic [PHASE_W-1:0] r_phase;
  logic [15:0]        r_prev_i;
  logic [15:0]        r_prev_q;
  logic [15:0]        r_prev_s;
  logic [15:0]        r_i_out;
  logic [15:0]        r_q_out;
  logic [15:0]        r_s_out;
  logic               r_valid_out;
  logic               r_underflow;
  logic [15:0]        r_uflow_cnt;

  logic               w_rise;
  strb_mode_e         w_mode;
  logic [PHASE_W-1:0] w_phase;
  logic               w_ready;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_uflow;
  iq_sample_t         w_wdata;
  iq_sample_t         w_head;
  logic [15:0]        w_cur_i;
  logic [15:0]        w_cur_q;
  logic [15:0]        w_cur_s;

  // The first enabled edge already uses the incoming mode/phase so the
  // priming words carry the right strobe pattern and alignment.
  assign w_rise  = enable && !r_en_d1;
  assign w_mode  = w_rise ? strb_mode_e'(strb_mode) : r_mode;
  assign w_phase = w_rise ? phase : r_phase;

  // Reset gates ready so the source sees no acceptance while held in reset
  assign w_ready       = rstn && enable && !w_full;
  assign w_push        = bus.valid_in && w_ready;
  assign w_pop         = enable && !w_empty;
  assign w_wdata.i     = bus.i_in;
  assign w_wdata.q     = bus.q_in;
  assign bus.ready_out = w_ready;

  // Idle words are inserted once primed; the priming edge is not an underflow
  assign w_uflow = enable && r_en_d1 && w_empty;

  // Stage A: current lane words
  assign w_cur_i = w_empty ? IDLE_I : w_head.i;
  assign w_cur_q = w_empty ? IDLE_Q : w_head.q;
  assign w_cur_s = strb_pattern(w_mode);

  adrv9001_tx_serdes_framer_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .flush (!enable),
    .push  (w_push),
    .wdata (w_wdata),
    .pop   (w_pop),
    .rdata (w_head),
    .full  (w_full),
    .empty (w_empty)
  );

  // Enable history, mode/phase latch and saturating underflow counter
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_en_d1     <= 1'b0;
      r_mode      <= STRB_MODE_8ON;
      r_phase     <= '0;
      r_uflow_cnt <= '0;
    end else begin
      r_en_d1 <= enable;
      if (w_rise) begin
        r_mode      <= w_mode;
        r_phase     <= w_phase;
        r_uflow_cnt <= '0;
      end else if (w_uflow && (r_uflow_cnt != 16'hFFFF)) begin
        r_uflow_cnt <= r_uflow_cnt + 16'd1;
      end
    end
  end

  // Stage B: shared barrel shift across the three lanes, registered outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_prev_i    <= '0;
      r_prev_q    <= '0;
      r_prev_s    <= '0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_s_out     <= '0;
      r_valid_out <= 1'b0;
      r_underflow <= 1'b0;
    end else if (!enable) begin
      r_prev_i    <= '0;
      r_prev_q    <= '0;
      r_prev_s    <= '0;
      r_i_out     <= '0;
      r_q_out     <= '0;
      r_s_out     <= '0;
      r_valid_out <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_prev_i    <= w_cur_i;
      r_prev_q    <= w_cur_q;
      r_prev_s    <= w_cur_s;
      r_i_out     <= lane_shift(r_prev_i, w_cur_i, w_phase);
      r_q_out     <= lane_shift(r_prev_q, w_cur_q, w_phase);
      r_s_out     <= lane_shift(r_prev_s, w_cur_s, w_phase);
      r_valid_out <= r_en_d1;
      r_underflow <= w_uflow;
    end
  end

  assign bus.i_out     = r_i_out;
  assign bus.q_out     = r_q_out;
  assign bus.strb_out  = r_s_out;
  assign bus.valid_out = r_valid_out;
  assign underflow     = r_underflow;
  assign uflow_cnt     = r_uflow_cnt;

endmodule
`default_nettype wire
